// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 16-bit instructions into a small FIFO for a multicycle core.
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr -> instruction memory request (registered, held until ack)
//   imem_ack/imem_rdata <- memory accept + returned word
//   instr_valid/instr/instr_pc -> buffer head; instr_ready <- core consumes head
//   redirect/redirect_pc <- core redirects fetch (flushes buffer)
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  state_t state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, tail_q;
  logic [15:0] instr_mem_q [DEPTH];
  logic [15:0] pc_mem_q [DEPTH];
  logic ack, push, pop, room;
  logic [15:0] redir_pc, pc_inc;
  // An ack only means something while a request is outstanding.
  assign ack = imem_ack && state_q != IDLE;
  // A redirect flushes the buffer, so neither the returned word nor a pop is credited.
  assign push = ack && state_q == BUSY && !redirect;
  assign pop = instr_valid && instr_ready && !redirect;
  assign count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
  assign room = count_d != FULL;
  assign redir_pc = redirect_pc & 16'hFFFE;
  assign pc_inc = fetch_pc_q + 16'd2;
  assign imem_req = state_q != IDLE;
  assign imem_addr = addr_q;
  assign instr_valid = count_q != '0;
  assign instr = instr_valid ? instr_mem_q[head_q] : '0;
  assign instr_pc = instr_valid ? pc_mem_q[head_q] : '0;
  // fetch_pc always names the next word wanted; in BUSY it equals imem_addr.
  always_comb begin
    state_d = state_q;
    fetch_pc_d = redirect ? redir_pc : fetch_pc_q;
    addr_d = addr_q;
    unique case (state_q)
      IDLE: if (!redirect && room) begin
        state_d = BUSY;
        addr_d = fetch_pc_q;
      end
      BUSY: if (ack) begin
        addr_d = redirect ? redir_pc : pc_inc;
        fetch_pc_d = redirect ? redir_pc : pc_inc;
        state_d = (redirect || room) ? BUSY : IDLE;
      end else if (redirect) begin
        // Request in flight must complete at its old address; its data is dropped.
        state_d = DRAIN;
      end
      DRAIN: if (ack) begin
        state_d = BUSY;
        addr_d = fetch_pc_d;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      count_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q <= addr_d;
      count_q <= count_d;
      if (redirect) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) begin
          instr_mem_q[tail_q] <= imem_rdata;
          pc_mem_q[tail_q] <= addr_q;
          tail_q <= tail_q + AW'(1);
        end
        if (pop) head_q <= head_q + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scoreboard bench for instr_fetch_unit (DEPTH 2, RESET_PC 0).
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic imem_req, imem_ack = 1'b0, instr_valid, instr_ready = 1'b0, redirect = 1'b0;
  logic [15:0] imem_addr, imem_rdata = '0, instr, instr_pc, redirect_pc = '0;
  int tests = 0, fails = 0, lat = 0, wait_n = 0, acks = 0;
  logic [31:0] sb [$];

  instr_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory returns 16'h1000 + address; expected head entries are {instr, pc}.
  task automatic expect_pc(input logic [15:0] pc);
    sb.push_back({16'h1000 + pc, pc});
  endtask

  // One clock: drive the memory model at the negedge, score any pop, advance to next negedge.
  task automatic step();
    int nl;
    logic [31:0] e;
    imem_ack = imem_req && (lat >= wait_n);
    imem_rdata = imem_ack ? 16'h1000 + imem_addr : 16'hDEAD;
    if (imem_ack) acks++;
    if (instr_valid && instr_ready && !redirect) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_extra: popped pc %h, expected no entry", instr_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_instr", instr, e[31:16]);
        chk("sb_pc", instr_pc, e[15:0]);
      end
    end
    nl = (imem_req && !imem_ack) ? lat + 1 : 0;
    @(posedge clk);
    lat = nl;
    @(negedge clk);
  endtask

  task automatic run_sb(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    chk(tag, 16'(sb.size()), 16'd0);
    instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    sb.delete();
    lat = 0;
    acks = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_req", 16'(imem_req), 16'd0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", 16'(instr_valid), 16'd0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc", instr_pc, 16'h0000);
    // Zero-wait streaming, one instruction per cycle
    do_reset();
    wait_n = 0;
    instr_ready = 1'b1;
    step();
    chk("t1_req", 16'(imem_req), 16'd1);
    chk("t1_addr", imem_addr, 16'h0000);
    step();
    expect_pc(16'h0000);
    expect_pc(16'h0002);
    expect_pc(16'h0004);
    for (int i = 0; i < 3; i++) begin
      chk("t1_valid", 16'(instr_valid), 16'd1);
      step();
    end
    chk("t1_done", 16'(sb.size()), 16'd0);
    instr_ready = 1'b0;
    // Backpressure: exactly DEPTH pushes, then resume at 0004
    do_reset();
    repeat (6) step();
    chk("t2_acks", 16'(acks), 16'd2);
    chk("t2_req", 16'(imem_req), 16'd0);
    chk("t2_pc", instr_pc, 16'h0000);
    chk("t2_valid", 16'(instr_valid), 16'd1);
    expect_pc(16'h0000);
    expect_pc(16'h0002);
    expect_pc(16'h0004);
    instr_ready = 1'b1;
    step();
    chk("t2_resume_req", 16'(imem_req), 16'd1);
    chk("t2_resume_addr", imem_addr, 16'h0004);
    run_sb("t2_drain", 10);
    // 3-cycle memory, redirect in the first request cycle
    do_reset();
    wait_n = 2;
    instr_ready = 1'b1;
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0041;
    step();
    redirect = 1'b0;
    chk("t3_valid", 16'(instr_valid), 16'd0);
    chk("t3_hold1", imem_addr, 16'h0000);
    step();
    chk("t3_hold2", imem_addr, 16'h0000);
    chk("t3_hold_req", 16'(imem_req), 16'd1);
    step();
    chk("t3_newaddr", imem_addr, 16'h0040);
    chk("t3_empty", 16'(instr_valid), 16'd0);
    expect_pc(16'h0040);
    expect_pc(16'h0042);
    run_sb("t3_drain", 20);
    // Redirect coinciding with ack and pop
    do_reset();
    wait_n = 0;
    instr_ready = 1'b1;
    step();
    step();
    chk("t4_pre_valid", 16'(instr_valid), 16'd1);
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    chk("t4_valid", 16'(instr_valid), 16'd0);
    chk("t4_instr", instr, 16'h0000);
    chk("t4_addr", imem_addr, 16'h0100);
    chk("t4_req", 16'(imem_req), 16'd1);
    expect_pc(16'h0100);
    expect_pc(16'h0102);
    run_sb("t4_drain", 10);
    // Address wrap at FFFE
    do_reset();
    wait_n = 0;
    instr_ready = 1'b1;
    step();
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    chk("t5_valid", 16'(instr_valid), 16'd0);
    chk("t5_addr", imem_addr, 16'hFFFE);
    expect_pc(16'hFFFE);
    expect_pc(16'h0000);
    expect_pc(16'h0002);
    run_sb("t5_drain", 10);
    // Reset mid-transaction with ack pulsed during and after reset
    do_reset();
    wait_n = 50;
    step();
    step();
    chk("t6_pending", 16'(imem_req), 16'd1);
    reset = 1'b0;
    #1;
    chk("t6_async_req", 16'(imem_req), 16'd0);
    chk("t6_async_valid", 16'(instr_valid), 16'd0);
    imem_ack = 1'b1;
    imem_rdata = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_req", 16'(imem_req), 16'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t6_req", 16'(imem_req), 16'd1);
    chk("t6_addr", imem_addr, 16'h0000);
    chk("t6_valid", 16'(instr_valid), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
